cm_config_scheduler: RTL

Arbitrates the color-manager configuration bus (addr/data/valid/ready) between two write requesters: S0 is the UART config path and S1 is the debug/host path. Optionally gates commits to a vertical-blanking window opened by VSync, so porch and color registers never change mid-frame. Optionally replays a boot-default register table after reset. Sits between the requesters and the assign-data register block.

---
 rtl/cm_cfg_pkg.sv | 39 +++
 rtl/cm_blank_window.sv | 48 ++++
 rtl/cm_config_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cm_cfg_pkg.sv
// Shared definitions for the color-manager config scheduler: FSM encoding,
// requester IDs and the boot-default register table (used when
// CM_BOOT_DEFAULTS_EN is defined).
package cm_cfg_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_XFER = 2'd2
  } cm_state_t;

  localparam int BOOT_DEPTH = 4;

  localparam logic REQ_S0 = 1'b0;
  localparam logic REQ_S1 = 1'b1;

  // Boot table address: porch registers live at addresses 0..3
  function automatic int boot_addr(input int idx);
    case (idx)
      0:       boot_addr = 0;
      1:       boot_addr = 1;
      2:       boot_addr = 2;
      3:       boot_addr = 3;
      default: boot_addr = 0;
    endcase
  endfunction

  // Boot table data: H back porch, H front porch, V back porch, V front porch
  function automatic int boot_data(input int idx);
    case (idx)
      0:       boot_data = 48;
      1:       boot_data = 16;
      2:       boot_data = 33;
      3:       boot_data = 10;
      default: boot_data = 0;
    endcase
  endfunction

endpackage

// File: rtl/cm_blank_window.sv
// Vertical-blanking commit window: registers VSync, detects the transition
// into the active level and holds window_open high for BLANK_CYCLES cycles.
module cm_blank_window #(
  parameter int   BLANK_CYCLES    = 64,
  parameter int   BLANK_CNT_WIDTH = 7,
  parameter logic VSYNC_ACTIVE    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic window_open
);

  logic                       vsync_p0;
  logic                       vsync_p1;
  logic                       vs_edge;
  logic [BLANK_CNT_WIDTH-1:0] cnt;

  assign vs_edge = (vsync_p0 == VSYNC_ACTIVE) && (vsync_p1 != VSYNC_ACTIVE);

  // Stage p0: synchronising register; stage p1: history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_p0 <= ~VSYNC_ACTIVE;
      vsync_p1 <= ~VSYNC_ACTIVE;
    end else begin
      vsync_p0 <= vsync;
      vsync_p1 <= vsync_p0;
    end
  end

  // Window counter: load on edge, count down, open while counter is 1..BLANK_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      window_open <= 1'b0;
    end else if (vs_edge) begin
      cnt         <= BLANK_CNT_WIDTH'(BLANK_CYCLES);
      window_open <= 1'b1;
    end else if (cnt != '0) begin
      cnt         <= cnt - 1'b1;
      window_open <= (cnt != BLANK_CNT_WIDTH'(1));
    end else begin
      window_open <= 1'b0;
    end
  end

endmodule

// File: rtl/cm_config_scheduler.sv
// Color-manager config bus scheduler: round-robin arbitration of two write
// requesters onto the register-block bus, optionally gated to the vertical
// blanking window. Optional feature macro CM_BOOT_DEFAULTS_EN replays the
// boot-default porch table after reset before serving requesters.
module cm_config_scheduler
  import cm_cfg_pkg::*;
#(
  parameter int   C_ADDR_WIDTH    = 4,
  parameter int   C_DATA_WIDTH    = 16,
  parameter int   BLANK_CYCLES    = 64,
  parameter int   BLANK_CNT_WIDTH = 7,
  parameter logic VSYNC_ACTIVE    = 1'b0
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    VSync,
  input  logic                    Frame_Sync_En,
  input  logic                    S0_Valid,
  input  logic [C_ADDR_WIDTH-1:0] S0_Addr,
  input  logic [C_DATA_WIDTH-1:0] S0_Data,
  output logic                    S0_Rdy,
  input  logic                    S1_Valid,
  input  logic [C_ADDR_WIDTH-1:0] S1_Addr,
  input  logic [C_DATA_WIDTH-1:0] S1_Data,
  output logic                    S1_Rdy,
  output logic                    M_Valid,
  output logic [C_ADDR_WIDTH-1:0] M_Addr,
  output logic [C_DATA_WIDTH-1:0] M_Data,
  input  logic                    M_Rdy,
  output logic                    Window_Open,
  output logic                    Last_Grant,
  output logic                    Boot_Done
);

`ifdef CM_BOOT_DEFAULTS_EN
  localparam cm_state_t RESET_STATE = ST_BOOT;
`else
  localparam cm_state_t RESET_STATE = ST_IDLE;
`endif

  cm_state_t state;
  logic      xfer_id;
  logic      eligible;
  logic      grant_s1;
  logic      accept;

  cm_blank_window #(
    .BLANK_CYCLES    (BLANK_CYCLES),
    .BLANK_CNT_WIDTH (BLANK_CNT_WIDTH),
    .VSYNC_ACTIVE    (VSYNC_ACTIVE)
  ) u_blank_window (
    .clk         (Clk),
    .rst         (rst),
    .vsync       (VSync),
    .window_open (Window_Open)
  );

  // Arbitration: ready pulses in the same cycle as the accept decision
  always_comb begin
    eligible = (S0_Valid || S1_Valid) && (!Frame_Sync_En || Window_Open);
    grant_s1 = S1_Valid && (!S0_Valid || (Last_Grant == REQ_S0));
    accept   = !rst && (state == ST_IDLE) && eligible;
    S0_Rdy   = accept && !grant_s1;
    S1_Rdy   = accept && grant_s1;
  end

`ifdef CM_BOOT_DEFAULTS_EN
  logic [1:0] boot_idx;
  logic [1:0] boot_nxt;
  logic       boot_done_q;

  assign boot_nxt  = boot_idx + 2'd1;
  assign Boot_Done = boot_done_q;
`else
  assign Boot_Done = 1'b1;
`endif

  // Scheduler FSM: boot replay, accept one requester beat, hold it until M_Rdy
  always_ff @(posedge Clk) begin
    if (rst) begin
      state       <= RESET_STATE;
      M_Valid     <= 1'b0;
      M_Addr      <= '0;
      M_Data      <= '0;
      Last_Grant  <= REQ_S1;
      xfer_id     <= REQ_S0;
`ifdef CM_BOOT_DEFAULTS_EN
      boot_idx    <= '0;
      boot_done_q <= 1'b0;
`endif
    end else begin
      case (state)
`ifdef CM_BOOT_DEFAULTS_EN
        ST_BOOT: begin
          if (!M_Valid) begin
            M_Valid <= 1'b1;
            M_Addr  <= C_ADDR_WIDTH'(boot_addr(int'(boot_idx)));
            M_Data  <= C_DATA_WIDTH'(boot_data(int'(boot_idx)));
          end else if (M_Rdy) begin
            if (boot_idx == 2'(BOOT_DEPTH - 1)) begin
              M_Valid     <= 1'b0;
              boot_done_q <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              boot_idx <= boot_nxt;
              M_Addr   <= C_ADDR_WIDTH'(boot_addr(int'(boot_nxt)));
              M_Data   <= C_DATA_WIDTH'(boot_data(int'(boot_nxt)));
            end
          end
        end
`endif
        ST_IDLE: begin
          if (accept) begin
            M_Valid <= 1'b1;
            M_Addr  <= grant_s1 ? S1_Addr : S0_Addr;
            M_Data  <= grant_s1 ? S1_Data : S0_Data;
            xfer_id <= grant_s1 ? REQ_S1 : REQ_S0;
            state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (M_Rdy) begin
            M_Valid    <= 1'b0;
            Last_Grant <= xfer_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
